// File: rtl/lcd_hex_streamer.sv
// lcd_hex_streamer: samples a slow chip-select on a programmable tick.
// On each rising edge of that select it latches a multi-nibble value.
// It then streams the value to the CLCD 8-bit write path as ASCII hex, MSN
// first, with one character per i_busy handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a sampled rising edge of i_cs
// SEND  | issue the current nibble as soon as i_busy is low
// GAP   | one quiet cycle after a strobe so the driver can raise i_busy
module lcd_hex_streamer #(
    parameter int P_NIBBLES    = 4,
    parameter int P_CNT_SAMPLE = 125_000,
    parameter int P_LOWER      = 0,
    parameter int P_BLANK      = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [4*P_NIBBLES-1:0] i_data,
    input  logic                   i_cs,
    input  logic                   i_busy,
    output logic [7:0]             o_data,
    output logic                   o_valid,
    output logic                   o_active,
    output logic                   o_drop
);

    localparam int CNT_W = (P_CNT_SAMPLE > 0) ? $clog2(P_CNT_SAMPLE + 1) : 1;
    localparam int IDX_W = (P_NIBBLES > 1) ? $clog2(P_NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(P_CNT_SAMPLE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_NIBBLES - 1);
    // 'A'-10 and 'a'-10, so that adding the nibble value lands on the letter
    localparam logic [7:0] LETTER_BASE = (P_LOWER != 0) ? 8'h57 : 8'h37;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             hist;
    logic                   tick;
    logic                   edge_det;
    logic [4*P_NIBBLES-1:0] shadow;
    logic [IDX_W-1:0]       idx;
    logic                   blank;
    logic [3:0]             cur_nib;
    logic                   is_last;
    logic [7:0]             cur_char;
    logic                   capture;
    logic                   issue;
    logic                   drop_nx;
    logic                   active_nx;

    // sample-tick counter: shifts i_cs into the history once per period
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt  <= '0;
            hist <= 2'b00;
            tick <= 1'b0;
        end else if (cnt == CNT_TC) begin
            cnt  <= '0;
            hist <= {hist[0], i_cs};
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

    // rising edge is qualified by tick so it lasts exactly one clock
    assign edge_det = tick && (hist == 2'b01);

    // select the nibble for the current index, most-significant first
    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < P_NIBBLES; i++) begin
            if (idx == IDX_W'(P_NIBBLES - 1 - i)) begin
                cur_nib = shadow[4*i +: 4];
            end
        end
    end

    assign is_last = (idx == IDX_LAST);

    // ASCII mapping with leading-zero blanking; the last nibble is never blanked
    always_comb begin
        if (blank && (cur_nib == 4'h0) && !is_last) begin
            cur_char = 8'h20;
        end else if (cur_nib < 4'd10) begin
            cur_char = 8'h30 + {4'h0, cur_nib};
        end else begin
            cur_char = LETTER_BASE + {4'h0, cur_nib};
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        issue    = 1'b0;
        drop_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (edge_det) begin
                    capture  = 1'b1;
                    state_nx = S_SEND;
                end
            end
            S_SEND: begin
                drop_nx = edge_det;
                if (!i_busy) begin
                    issue    = 1'b1;
                    state_nx = is_last ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                drop_nx  = edge_det;
                state_nx = S_SEND;
            end
            default: state_nx = S_IDLE;
        endcase
        // keep active through the final strobe cycle, when the FSM is already IDLE
        active_nx = (state_nx != S_IDLE) || (issue && is_last);
    end

    // shadow value, nibble index, blank flag and registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shadow   <= '0;
            idx      <= '0;
            blank    <= 1'b0;
            o_data   <= 8'h00;
            o_valid  <= 1'b0;
            o_active <= 1'b0;
            o_drop   <= 1'b0;
        end else begin
            o_valid  <= issue;
            o_data   <= issue ? cur_char : 8'h00;
            o_active <= active_nx;
            o_drop   <= drop_nx;
            if (capture) begin
                shadow <= i_data;
                idx    <= '0;
                blank  <= (P_BLANK != 0);
            end else if (issue) begin
                idx <= is_last ? '0 : idx + IDX_W'(1);
                if (cur_nib != 4'h0) begin
                    blank <= 1'b0;
                end
            end
        end
    end

endmodule
